// File: rtl/branch_predictor_gshare_if.sv
// Fetch-lookup and execute-update signal bundle for the gshare branch predictor.
// The master drives lookups and resolved updates; the slave is the predictor.
interface branch_predictor_gshare_if #(
    parameter int XLEN  = 32,
    parameter int GHR_W = 6
) ();
    localparam int GHW = (GHR_W > 0) ? GHR_W : 1;

    logic [XLEN-1:0] F_pc;
    logic [XLEN-1:0] F_next_pc;
    logic            F_predict;
    logic [GHW-1:0]  F_ghr;

    logic            E_upd_valid;
    logic [XLEN-1:0] E_upd_pc;
    logic [GHW-1:0]  E_upd_ghr;
    logic            E_upd_is_jump;
    logic            E_upd_taken;
    logic [XLEN-1:0] E_upd_target;
    logic            E_upd_mispredict;

    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;

    modport master (
        output F_pc, E_upd_valid, E_upd_pc, E_upd_ghr, E_upd_is_jump, E_upd_taken,
               E_upd_target, E_upd_mispredict,
        input  F_next_pc, F_predict, F_ghr, stat_branches, stat_mispred
    );

    modport slave (
        input  F_pc, E_upd_valid, E_upd_pc, E_upd_ghr, E_upd_is_jump, E_upd_taken,
               E_upd_target, E_upd_mispredict,
        output F_next_pc, F_predict, F_ghr, stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor: direct-mapped BTB plus saturating counters,
// combinational F-stage lookup, registered E-stage update and saturating statistics.
module branch_predictor_gshare #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 6,
    parameter int TAG_W   = 8
) (
    input logic                      clk,
    input logic                      rst,
    branch_predictor_gshare_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int GHW   = (GHR_W > 0) ? GHR_W : 1;

    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntInit = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0] cnt_q        [ENTRIES];
    logic [ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0] btb_tag_q    [ENTRIES];
    logic [XLEN-1:0]  btb_target_q [ENTRIES];
    logic [GHW-1:0]   ghr_q;
    logic [GHW-1:0]   ghr_d;
    logic [31:0]      stat_branches_q;
    logic [31:0]      stat_mispred_q;

    function automatic logic [IDX_W-1:0] hist_idx(input logic [XLEN-1:0] pc,
                                                  input logic [GHW-1:0]  ghr);
        logic [IDX_W-1:0] h;
        h = (GHR_W > 0) ? IDX_W'(ghr) : '0;
        return pc[IDX_W+1:2] ^ h;
    endfunction

    // Lookup
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] f_bidx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_predict;

    assign f_idx     = hist_idx(bus.F_pc, ghr_q);
    assign f_bidx    = bus.F_pc[IDX_W+1:2];
    assign f_tag     = bus.F_pc[IDX_W+2 +: TAG_W];
    assign f_hit     = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
    assign f_predict = f_hit && cnt_q[f_idx][CNT_W-1];

    assign bus.F_predict     = f_predict;
    assign bus.F_next_pc     = f_predict ? btb_target_q[f_bidx] : bus.F_pc + XLEN'(4);
    assign bus.F_ghr         = ghr_q;
    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_mispred  = stat_mispred_q;

    // Update: indexed with the snapshot the branch was predicted with, not the live GHR
    logic [IDX_W-1:0] u_idx;
    logic [IDX_W-1:0] u_bidx;
    logic [CNT_W-1:0] cnt_upd;

    assign u_idx  = hist_idx(bus.E_upd_pc, bus.E_upd_ghr);
    assign u_bidx = bus.E_upd_pc[IDX_W+1:2];

    always_comb begin
        cnt_upd = cnt_q[u_idx];
        if (bus.E_upd_is_jump) begin
            cnt_upd = CntMax;
        end else if (bus.E_upd_taken) begin
            if (cnt_upd != CntMax) cnt_upd = cnt_upd + CNT_W'(1);
        end else if (cnt_upd != '0) begin
            cnt_upd = cnt_upd - CNT_W'(1);
        end
    end

    generate
        if (GHR_W == 0) begin : gen_ghr_none
            assign ghr_d = '0;
        end else if (GHR_W == 1) begin : gen_ghr_one
            assign ghr_d = bus.E_upd_taken;
        end else begin : gen_ghr_shift
            assign ghr_d = {ghr_q[GHW-2:0], bus.E_upd_taken};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CntInit;
            btb_valid_q     <= '0;
            ghr_q           <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else if (bus.E_upd_valid) begin
            cnt_q[u_idx] <= cnt_upd;
            if (bus.E_upd_taken) btb_valid_q[u_bidx] <= 1'b1;
            ghr_q <= ghr_d;
            if (stat_branches_q != 32'hFFFF_FFFF) stat_branches_q <= stat_branches_q + 32'd1;
            if (bus.E_upd_mispredict && (stat_mispred_q != 32'hFFFF_FFFF)) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    // Tag/target storage is only meaningful behind a valid bit, so it carries no reset
    always_ff @(posedge clk) begin
        if (!rst && bus.E_upd_valid && bus.E_upd_taken) begin
            btb_tag_q[u_bidx]    <= bus.E_upd_pc[IDX_W+2 +: TAG_W];
            btb_target_q[u_bidx] <= bus.E_upd_target;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.F_pc, bus.E_upd_pc, bus.E_upd_ghr};
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench: one bimodal (GHR_W=0) and one gshare (GHR_W=6) predictor driven with
// directed vectors; expectations are queued at issue and checked by a negedge monitor.
module tb_branch_predictor_gshare;
    logic clk;
    logic rst;
    int   cycle;
    int   n_checks;
    int   n_fail;

    branch_predictor_gshare_if #(.XLEN(32), .GHR_W(0)) bim_if ();
    branch_predictor_gshare_if #(.XLEN(32), .GHR_W(6)) gsh_if ();

    branch_predictor_gshare #(
        .XLEN(32), .ENTRIES(64), .CNT_W(2), .GHR_W(0), .TAG_W(8)
    ) u_bim (
        .clk (clk),
        .rst (rst),
        .bus (bim_if)
    );

    branch_predictor_gshare #(
        .XLEN(32), .ENTRIES(64), .CNT_W(2), .GHR_W(6), .TAG_W(8)
    ) u_gsh (
        .clk (clk),
        .rst (rst),
        .bus (gsh_if)
    );

    typedef struct {
        int          cyc;
        int          dut;
        logic        pred;
        logic [31:0] npc;
        logic [5:0]  ghr;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];

    logic [31:0] exp_sb [2];
    logic [31:0] exp_sm [2];
    logic        pend_valid [2];
    logic        pend_mis [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor
    exp_t        e;
    string       nm;
    logic        a_pred;
    logic [31:0] a_npc;
    logic [5:0]  a_ghr;
    logic [31:0] a_sb;
    logic [31:0] a_sm;

    always @(negedge clk) begin
        while (sb_q.size() != 0 && sb_q[0].cyc <= cycle) begin
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            if (e.dut == 0) begin
                a_pred = bim_if.F_predict;
                a_npc  = bim_if.F_next_pc;
                a_ghr  = 6'(bim_if.F_ghr);
                a_sb   = bim_if.stat_branches;
                a_sm   = bim_if.stat_mispred;
            end else begin
                a_pred = gsh_if.F_predict;
                a_npc  = gsh_if.F_next_pc;
                a_ghr  = gsh_if.F_ghr;
                a_sb   = gsh_if.stat_branches;
                a_sm   = gsh_if.stat_mispred;
            end
            n_checks++;
            if (e.cyc != cycle || a_pred !== e.pred || a_npc !== e.npc || a_ghr !== e.ghr ||
                a_sb !== e.sb || a_sm !== e.sm) begin
                n_fail++;
                $display("FAIL %s: got pred=%0b npc=%h ghr=%h br=%h mis=%h, want pred=%0b npc=%h ghr=%h br=%h mis=%h (cycle %0d, due %0d)",
                         nm, a_pred, a_npc, a_ghr, a_sb, a_sm,
                         e.pred, e.npc, e.ghr, e.sb, e.sm, cycle, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                exp_sb[d] = '0;
                exp_sm[d] = '0;
            end else if (pend_valid[d]) begin
                if (exp_sb[d] != 32'hFFFF_FFFF) exp_sb[d] = exp_sb[d] + 1;
                if (pend_mis[d] && exp_sm[d] != 32'hFFFF_FFFF) exp_sm[d] = exp_sm[d] + 1;
            end
            pend_valid[d] = 1'b0;
        end
        #1;
        bim_if.E_upd_valid = 1'b0;
        gsh_if.E_upd_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic drive_upd(input int d, input logic [31:0] pc, input logic [5:0] ghr,
                             input logic jmp, input logic tkn, input logic [31:0] tgt,
                             input logic mis);
        if (d == 0) begin
            bim_if.E_upd_valid      = 1'b1;
            bim_if.E_upd_pc         = pc;
            bim_if.E_upd_ghr        = ghr[0];
            bim_if.E_upd_is_jump    = jmp;
            bim_if.E_upd_taken      = tkn;
            bim_if.E_upd_target     = tgt;
            bim_if.E_upd_mispredict = mis;
        end else begin
            gsh_if.E_upd_valid      = 1'b1;
            gsh_if.E_upd_pc         = pc;
            gsh_if.E_upd_ghr        = ghr;
            gsh_if.E_upd_is_jump    = jmp;
            gsh_if.E_upd_taken      = tkn;
            gsh_if.E_upd_target     = tgt;
            gsh_if.E_upd_mispredict = mis;
        end
        pend_valid[d] = 1'b1;
        pend_mis[d]   = mis;
    endtask

    task automatic look(input int d, input string name, input logic [31:0] pc,
                        input logic pred, input logic [31:0] npc, input logic [5:0] ghr);
        exp_t x;
        if (d == 0) bim_if.F_pc = pc;
        else        gsh_if.F_pc = pc;
        x.cyc  = cycle;
        x.dut  = d;
        x.pred = pred;
        x.npc  = npc;
        x.ghr  = ghr;
        x.sb   = exp_sb[d];
        x.sm   = exp_sm[d];
        sb_q.push_back(x);
        name_q.push_back(name);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int d = 0; d < 2; d++) begin
            exp_sb[d] = '0; exp_sm[d] = '0; pend_valid[d] = 1'b0; pend_mis[d] = 1'b0;
        end
        bim_if.F_pc = '0; bim_if.E_upd_valid = 0; bim_if.E_upd_pc = '0; bim_if.E_upd_ghr = '0;
        bim_if.E_upd_is_jump = 0; bim_if.E_upd_taken = 0; bim_if.E_upd_target = '0;
        bim_if.E_upd_mispredict = 0;
        gsh_if.F_pc = '0; gsh_if.E_upd_valid = 0; gsh_if.E_upd_pc = '0; gsh_if.E_upd_ghr = '0;
        gsh_if.E_upd_is_jump = 0; gsh_if.E_upd_taken = 0; gsh_if.E_upd_target = '0;
        gsh_if.E_upd_mispredict = 0;
        rst = 1'b1;
        tick();

        look(0, "rst_bim", 32'h100, 0, 32'h104, 6'h00);
        look(1, "rst_gsh", 32'h100, 0, 32'h104, 6'h00);
        tick();

        // Bimodal training of branch 0x200 -> 0x80 (counter 1 -> 2 -> saturate 3)
        drive_upd(0, 32'h200, 6'h00, 0, 1, 32'h80, 1); tick();
        look(0, "bim_taken1", 32'h200, 1, 32'h80, 6'h00); tick();
        repeat (4) begin drive_upd(0, 32'h200, 6'h00, 0, 1, 32'h80, 0); tick(); end
        look(0, "bim_sat", 32'h200, 1, 32'h80, 6'h00); tick();
        drive_upd(0, 32'h200, 6'h00, 0, 0, 32'h80, 1); tick();
        look(0, "bim_nt1", 32'h200, 1, 32'h80, 6'h00); tick();
        drive_upd(0, 32'h200, 6'h00, 0, 0, 32'h80, 1); tick();
        look(0, "bim_nt2", 32'h200, 0, 32'h204, 6'h00); tick();

        // Jump at 0x300 shares idx 0 with 0x200 and evicts its BTB entry
        drive_upd(0, 32'h300, 6'h00, 1, 1, 32'h1000, 1); tick();
        look(0, "bim_jump", 32'h300, 1, 32'h1000, 6'h00); tick();
        look(0, "bim_alias", 32'h400, 0, 32'h404, 6'h00); tick();
        look(0, "bim_evict", 32'h200, 0, 32'h204, 6'h00); tick();
        look(0, "bim_wrap", 32'hFFFF_FFFC, 0, 32'h0, 6'h00); tick();

        // Same-cycle lookup and update: old value now, new value next cycle
        drive_upd(0, 32'h104, 6'h00, 0, 1, 32'h40, 0);
        look(0, "bim_same_old", 32'h104, 0, 32'h108, 6'h00); tick();
        look(0, "bim_same_new", 32'h104, 1, 32'h40, 6'h00); tick();
        repeat (3) tick();
        look(0, "bim_idle", 32'h104, 1, 32'h40, 6'h00); tick();

        // Gshare: history taken, not-taken, taken -> 000101
        drive_upd(1, 32'h200, 6'h00, 0, 1, 32'h80, 0); tick();
        drive_upd(1, 32'h200, 6'h01, 0, 0, 32'h80, 0); tick();
        drive_upd(1, 32'h200, 6'h02, 0, 1, 32'h80, 0); tick();
        look(1, "gsh_ghr05", 32'h200, 0, 32'h204, 6'h05); tick();
        drive_upd(1, 32'h200, 6'h05, 0, 1, 32'h80, 0); tick();
        look(1, "gsh_h0b", 32'h200, 0, 32'h204, 6'h0B); tick();
        // Snapshot 0x17 differs from live history 0x0B
        drive_upd(1, 32'h200, 6'h17, 0, 1, 32'h80, 0); tick();
        look(1, "gsh_h17", 32'h200, 1, 32'h80, 6'h17); tick();
        drive_upd(1, 32'h200, 6'h05, 0, 1, 32'h80, 0); tick();
        look(1, "gsh_h2f", 32'h200, 0, 32'h204, 6'h2F); tick();

        // Reset in the middle of an update stream; concurrent update discarded
        drive_upd(0, 32'h10C, 6'h00, 0, 1, 32'h30, 0);
        drive_upd(1, 32'h200, 6'h2F, 0, 1, 32'h80, 0);
        tick();
        rst = 1'b1;
        drive_upd(0, 32'h108, 6'h00, 0, 1, 32'h20, 1);
        drive_upd(1, 32'h200, 6'h2F, 0, 1, 32'h80, 1);
        tick();
        look(0, "rst_bim_104", 32'h104, 0, 32'h108, 6'h00);
        look(1, "rst_gsh_mid", 32'h200, 0, 32'h204, 6'h00);
        tick();
        look(0, "rst_bim_108", 32'h108, 0, 32'h10C, 6'h00); tick();
        look(0, "rst_bim_10c", 32'h10C, 0, 32'h110, 6'h00); tick();
        drive_upd(0, 32'h104, 6'h00, 0, 1, 32'h44, 0); tick();
        look(0, "rst_cnt_init", 32'h104, 1, 32'h44, 6'h00); tick();

        // Statistics saturation
        force u_bim.stat_branches_q = 32'hFFFF_FFFE;
        force u_bim.stat_mispred_q  = 32'hFFFF_FFFE;
        #1;
        release u_bim.stat_branches_q;
        release u_bim.stat_mispred_q;
        exp_sb[0] = 32'hFFFF_FFFE;
        exp_sm[0] = 32'hFFFF_FFFE;
        look(0, "stat_preload", 32'h104, 1, 32'h44, 6'h00); tick();
        repeat (2) begin drive_upd(0, 32'h600, 6'h00, 0, 0, 32'h0, 1); tick(); end
        look(0, "stat_sat", 32'h104, 1, 32'h44, 6'h00); tick();
        drive_upd(0, 32'h600, 6'h00, 0, 0, 32'h0, 1); tick();
        look(0, "stat_hold", 32'h104, 1, 32'h44, 6'h00); tick();

        repeat (2) tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
